alu_req_arbiter: RTL and testbench

- Shares one 8-bit ALU (ADD/SUB/AND/OR, 2-bit select) between two requesters.
- Round-robin arbitration, registered operand issue, and a held response with valid/ready handshake.
- Sits between the two client blocks and the ALU datapath. The ALU ports are external, so this block is purely the controller.

---
 rtl/alu_req_arbiter_pkg.sv | 20 ++
 rtl/alu_req_arbiter_if.sv | 41 ++++
 rtl/alu_req_arbiter_rr_arbiter_2.sv | 24 ++
 rtl/alu_req_arbiter.sv | 114 +++++++++++
 tb/tb_alu_req_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter slice.
// Holds ALU select encodings, the controller state type and default widths.
package alu_req_arbiter_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned OP_W_DEFAULT   = 2;
  localparam int unsigned CNT_W_DEFAULT  = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bus bundle for alu_req_arbiter: requester handshakes, response channel,
// ALU operand/result wires and status.
//   slave  : the arbiter side (drives req_ready, rsp_*, alu_a/b/sel, busy, op_count)
//   master : the environment side (clients + ALU datapath)
// Requester i occupies bits [W*i +: W] of the packed req_a/req_b/req_op buses.
interface alu_req_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 2,
  parameter int unsigned CNT_W  = 8
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_cout;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_sel;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_cout;
  logic                busy;
  logic [CNT_W-1:0]    op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_cout,
    output req_ready, rsp_valid, rsp_data, rsp_cout, alu_a, alu_b, alu_sel,
           busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_cout,
    input  req_ready, rsp_valid, rsp_data, rsp_cout, alu_a, alu_b, alu_sel,
           busy, op_count
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant, purely combinational.
//   req_valid   : request bits (bit i = requester i)
//   last_grant  : requester granted most recently
//   grant_valid : at least one request present
//   grant_idx   : granted requester; on a tie the one that did not win last
module rr_arbiter_2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req_valid;
    grant_idx   = 1'b0;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Controller sharing one external ALU between two requesters.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : alu_req_arbiter_if.slave
//     req_valid/req_ready/req_a/req_b/req_op : per-requester request handshake
//     rsp_valid/rsp_ready/rsp_data/rsp_cout  : held response to the owner
//     alu_a/alu_b/alu_sel -> ALU, alu_result/alu_cout <- ALU
//     busy (state != IDLE), op_count (completed responses, wrapping)
// Flow: IDLE grants and registers operands, EXEC captures the ALU output,
// RESP holds it until the owner accepts.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned OP_W   = OP_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  alu_req_arbiter_if.slave bus
);

  state_t            state, state_d;
  logic              last_grant;
  logic              owner;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              accept;
  logic              done;
  logic [1:0]        req_ready_c;
  logic [1:0]        rsp_valid_c;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [OP_W-1:0]   alu_sel_q;
  logic              rsp_cout_q;
  logic              busy_q;
  logic [CNT_W-1:0]  op_count_q;

  rr_arbiter_2 u_rr (
    .req_valid   (bus.req_valid),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  always_comb begin
    state_d     = state;
    req_ready_c = '0;
    rsp_valid_c = '0;
    accept      = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // rst gate keeps req_ready low while reset is held with requests pending
        if (gnt_valid && !rst) begin
          req_ready_c[gnt_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_c[owner] = 1'b1;
        if (bus.rsp_ready[owner]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      busy_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state  <= state_d;
      // registered from next state so busy lines up with the state register
      busy_q <= (state_d != IDLE);
      if (accept) begin
        owner      <= gnt_idx;
        last_grant <= gnt_idx;
        alu_a_q    <= gnt_idx ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
        alu_b_q    <= gnt_idx ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
        alu_sel_q  <= gnt_idx ? bus.req_op[2*OP_W-1:OP_W]    : bus.req_op[OP_W-1:0];
      end
      if (state == EXEC) begin
        rsp_data_q <= bus.alu_result;
        rsp_cout_q <= bus.alu_cout;
      end
      if (done) begin
        op_count_q <= op_count_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.busy      = busy_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
  import alu_req_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   cnt;

  alu_req_arbiter_if #(.DATA_W(8), .OP_W(2), .CNT_W(8)) bus ();

  alu_req_arbiter #(.DATA_W(8), .OP_W(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU model
  always_comb begin
    bus.alu_result = '0;
    bus.alu_cout   = 1'b0;
    case (bus.alu_sel)
      ALU_ADD: {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs set by caller, block in IDLE; owner accepts as soon as valid.
  task automatic run_op(input logic [1:0] gnt, input logic [7:0] data,
                        input logic cout, input string tag);
    #1;
    chk({tag, "_req_ready"}, bus.req_ready, gnt);
    step();
    step();
    chk({tag, "_rsp_valid"}, bus.rsp_valid, gnt);
    chk({tag, "_rsp_data"}, bus.rsp_data, data);
    chk({tag, "_rsp_cout"}, bus.rsp_cout, cout);
    bus.rsp_ready = gnt;
    step();
    cnt++;
    chk({tag, "_op_count"}, bus.op_count, cnt[7:0]);
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cnt = 0;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 2'b00;

    // Reset state
    #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_op_count", bus.op_count, 8'h00);
    chk("rst_alu_a", bus.alu_a, 8'h00);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    step();

    // Single request: 0F + 01
    bus.req_a[7:0] = 8'h0F;
    bus.req_b[7:0] = 8'h01;
    bus.req_op[1:0] = ALU_ADD;
    bus.req_valid = 2'b01;
    #1;
    chk("t1_req_ready", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b00;
    chk("t1_alu_a", bus.alu_a, 8'h0F);
    chk("t1_alu_b", bus.alu_b, 8'h01);
    chk("t1_alu_sel", bus.alu_sel, 2'b00);
    chk("t1_busy_exec", bus.busy, 1'b1);
    chk("t1_rsp_valid_exec", bus.rsp_valid, 2'b00);
    step();
    chk("t1_rsp_valid", bus.rsp_valid, 2'b01);
    chk("t1_rsp_data", bus.rsp_data, 8'h10);
    chk("t1_rsp_cout", bus.rsp_cout, 1'b0);
    bus.rsp_ready = 2'b01;
    step();
    cnt = 1;
    chk("t1_op_count", bus.op_count, 8'h01);
    chk("t1_busy_idle", bus.busy, 1'b0);
    chk("t1_rsp_valid_idle", bus.rsp_valid, 2'b00);
    bus.rsp_ready = 2'b00;
    step();
    chk("t1_alu_a_hold", bus.alu_a, 8'h0F);

    // Carry path on requester 1
    bus.req_a[15:8] = 8'hFF;
    bus.req_b[15:8] = 8'h01;
    bus.req_op[3:2] = ALU_ADD;
    bus.req_valid = 2'b10;
    run_op(2'b10, 8'h00, 1'b1, "carry");

    // Tie fairness: both valid continuously
    bus.req_a[7:0] = 8'h05;
    bus.req_b[7:0] = 8'h07;
    bus.req_op[1:0] = ALU_SUB;
    bus.req_a[15:8] = 8'hF0;
    bus.req_b[15:8] = 8'h3C;
    bus.req_op[3:2] = ALU_AND;
    bus.req_valid = 2'b11;
    run_op(2'b01, 8'hFE, 1'b0, "tie0");
    run_op(2'b10, 8'h30, 1'b0, "tie1");
    run_op(2'b01, 8'hFE, 1'b0, "tie2");
    run_op(2'b10, 8'h30, 1'b0, "tie3");
    bus.req_valid = 2'b00;

    // Backpressure: 12 + 34 held while non-owner pulses rsp_ready
    bus.req_a[7:0] = 8'h12;
    bus.req_b[7:0] = 8'h34;
    bus.req_op[1:0] = ALU_ADD;
    bus.req_valid = 2'b01;
    #1;
    chk("bp_req_ready", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.rsp_ready = (i % 2 == 0) ? 2'b10 : 2'b00;
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
      chk("bp_rsp_data", bus.rsp_data, 8'h46);
      chk("bp_busy", bus.busy, 1'b1);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_op_count", bus.op_count, cnt[7:0]);
      step();
    end
    bus.rsp_ready = 2'b01;
    #1;
    chk("bp_no_accept_on_done", bus.req_ready, 2'b00);
    step();
    cnt++;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    chk("bp_op_count_done", bus.op_count, cnt[7:0]);
    chk("bp_busy_done", bus.busy, 1'b0);

    // Reset while a response is pending
    bus.req_a[7:0] = 8'h01;
    bus.req_b[7:0] = 8'h02;
    bus.req_valid = 2'b01;
    #1;
    step();
    bus.req_valid = 2'b00;
    step();
    chk("mr_rsp_valid_pre", bus.rsp_valid, 2'b01);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("mr_rsp_valid", bus.rsp_valid, 2'b00);
    chk("mr_busy", bus.busy, 1'b0);
    chk("mr_op_count", bus.op_count, 8'h00);
    chk("mr_req_ready", bus.req_ready, 2'b00);
    step();
    rst = 1'b0;
    #1;
    chk("mr_first_tie", bus.req_ready, 2'b01);
    // Requester drop before the edge: no transaction
    bus.req_valid = 2'b00;
    step();
    chk("drop_busy", bus.busy, 1'b0);
    chk("drop_op_count", bus.op_count, 8'h00);

    // Counter wrap: 256 OR operations
    bus.req_a[7:0] = 8'hA0;
    bus.req_b[7:0] = 8'h05;
    bus.req_op[1:0] = ALU_OR;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    repeat (3 * 255) step();
    chk("wrap_op_count_255", bus.op_count, 8'hFF);
    chk("wrap_rsp_data", bus.rsp_data, 8'hA5);
    repeat (3) step();
    chk("wrap_op_count_0", bus.op_count, 8'h00);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
